// File: rtl/accumulator_controller.sv
// Per-slot point accumulator: sums packed unsigned coordinates and counts points
// into centroid_num slots, with a one-cycle clear and a handshaked slot readout.
module accumulator_controller #(
  parameter int dataWidth        = 91,
  parameter int cordinate_width  = 13,
  parameter int accum_cord_width = 22,
  parameter int accum_width      = 7 * 22,
  parameter int centroid_num     = 8,
  parameter int count_width      = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            pt_valid,
  output logic                            pt_ready,
  input  logic [dataWidth-1:0]            pt_data,
  input  logic [$clog2(centroid_num)-1:0] pt_idx,
  input  logic                            drain,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(centroid_num)-1:0] out_idx,
  output logic [accum_width-1:0]          out_accum,
  output logic [count_width-1:0]          out_count,
  output logic                            cnt_sat,
  output logic                            busy
);

  localparam int idx_width = $clog2(centroid_num);
  localparam int num_cord  = dataWidth / cordinate_width;
  localparam logic [idx_width-1:0]   last_idx = idx_width'(centroid_num - 1);
  localparam logic [count_width-1:0] cnt_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAIN
  } state_t;

  state_t                 r_state;
  logic [idx_width-1:0]   r_ptr;
  logic                   r_sat;
  logic [accum_width-1:0] r_accum [centroid_num];
  logic [count_width-1:0] r_count [centroid_num];

  // Each coordinate lane wraps on its own; no carry crosses into the next lane.
  function automatic logic [accum_width-1:0] add_point(
    input logic [accum_width-1:0] acc,
    input logic [dataWidth-1:0]   pt
  );
    logic [accum_width-1:0]      sum;
    logic [accum_cord_width-1:0] lane;
    sum = acc;
    for (int c = 0; c < num_cord; c++) begin
      lane = acc[c*accum_cord_width +: accum_cord_width]
           + accum_cord_width'(pt[c*cordinate_width +: cordinate_width]);
      sum[c*accum_cord_width +: accum_cord_width] = lane;
    end
    return sum;
  endfunction

  // NOTE: the slot arrays sit on the async reset like any other state, because
  // an asserted rst_n must leave every slot reading zero with no clear needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sat   <= 1'b0;
      for (int s = 0; s < centroid_num; s++) begin
        r_accum[s] <= '0;
        r_count[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout, so every slot update and the state change
      // see the values from before this edge.
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state <= S_CLEAR;
          end else if (drain) begin
            r_state <= S_DRAIN;
            r_ptr   <= '0;
          end else if (pt_valid) begin
            // An index with no matching slot is accepted and dropped.
            for (int s = 0; s < centroid_num; s++) begin
              if (pt_idx == s[idx_width-1:0]) begin
                r_accum[s] <= add_point(r_accum[s], pt_data);
                if (r_count[s] == cnt_max) r_sat <= 1'b1;
                else                       r_count[s] <= r_count[s] + 1'b1;
              end
            end
          end
        end

        S_CLEAR: begin
          r_state <= S_IDLE;
          r_sat   <= 1'b0;
          for (int s = 0; s < centroid_num; s++) begin
            r_accum[s] <= '0;
            r_count[s] <= '0;
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            if (r_ptr == last_idx) begin
              r_state <= S_IDLE;
              r_ptr   <= '0;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // pt_ready follows IDLE; a point offered alongside clear or drain is dropped.
  assign pt_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DRAIN);
  assign out_idx   = r_ptr;
  assign out_accum = r_accum[r_ptr];
  assign out_count = r_count[r_ptr];
  assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_accumulator_controller.sv
// Directed self-checking bench for accumulator_controller: accumulation, lane
// wrap, counter saturation, clear/drain priority, stalled readout and reset abort.
module tb_accumulator_controller;

  localparam int DW = 91;
  localparam int CW = 13;
  localparam int AC = 22;
  localparam int AW = 7 * 22;
  localparam int NS = 8;
  localparam int KW = 10;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          pt_valid;
  logic          pt_ready;
  logic [DW-1:0] pt_data;
  logic [2:0]    pt_idx;
  logic          drain;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_idx;
  logic [AW-1:0] out_accum;
  logic [KW-1:0] out_count;
  logic          cnt_sat;
  logic          busy;

  accumulator_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .pt_data   (pt_data),
    .pt_idx    (pt_idx),
    .drain     (drain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_accum (out_accum),
    .out_count (out_count),
    .cnt_sat   (cnt_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_acc [NS];
  logic [KW-1:0] exp_cnt [NS];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pt2(input int a, input int b);
    logic [DW-1:0] p;
    p = '0;
    p[CW-1:0]    = CW'(a);
    p[2*CW-1:CW] = CW'(b);
    return p;
  endfunction

  function automatic logic [DW-1:0] pt_all(input int v);
    logic [DW-1:0] p;
    for (int c = 0; c < 7; c++) p[c*CW +: CW] = CW'(v);
    return p;
  endfunction

  function automatic logic [AW-1:0] acc_all(input int v);
    logic [AW-1:0] a;
    for (int c = 0; c < 7; c++) a[c*AC +: AC] = AC'(v);
    return a;
  endfunction

  task automatic expect_zero();
    for (int s = 0; s < NS; s++) begin
      exp_acc[s] = '0;
      exp_cnt[s] = '0;
    end
  endtask

  // Called at a negedge; offers n consecutive points and returns at a negedge.
  task automatic feed(input int idx, input logic [DW-1:0] d, input int n);
    pt_valid = 1'b1;
    pt_idx   = 3'(idx);
    pt_data  = d;
    repeat (n) @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_busy", busy, 1);
    check("clear_ready", pt_ready, 0);
    check("clear_valid", out_valid, 0);
    @(negedge clk);
    check("clear_done_busy", busy, 0);
    check("clear_done_ready", pt_ready, 1);
    check("clear_sat", cnt_sat, 0);
  endtask

  // Reads all slots against exp_acc/exp_cnt. stall uses out_ready 1,0,0,1;
  // interfere holds clear and a point on slot 6 during DRAIN; start_pt offers
  // a point on slot 4 in the drain-start cycle.
  task automatic run_drain(input bit stall, input bit interfere, input bit start_pt);
    int       idx;
    int       cyc;
    bit       rdy;
    bit [3:0] pat;
    idx = 0;
    cyc = 0;
    pat = 4'b1001;
    drain = 1'b1;
    if (start_pt) begin
      pt_valid = 1'b1;
      pt_idx   = 3'd4;
      pt_data  = pt_all(9);
    end
    @(negedge clk);
    drain    = 1'b0;
    pt_valid = 1'b0;
    check("drain_busy", busy, 1);
    check("drain_ready", pt_ready, 0);
    if (interfere) begin
      clear    = 1'b1;
      pt_valid = 1'b1;
      pt_idx   = 3'd6;
      pt_data  = pt_all(11);
    end
    while (idx < NS && cyc < 100) begin
      check($sformatf("valid_w%0d", idx), out_valid, 1);
      check($sformatf("idx_w%0d", idx), out_idx, idx);
      check($sformatf("acc_w%0d", idx), out_accum, exp_acc[idx]);
      check($sformatf("cnt_w%0d", idx), out_count, exp_cnt[idx]);
      rdy = stall ? pat[cyc % 4] : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    check("drain_words", idx, NS);
    check("drain_end_valid", out_valid, 0);
    check("drain_end_busy", busy, 0);
    clear     = 1'b0;
    pt_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    clear     = 1'b0;
    pt_valid  = 1'b0;
    pt_data   = '0;
    pt_idx    = '0;
    drain     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", out_idx, 0);
    check("rst_sat", cnt_sat, 0);
    check("rst_cnt", out_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", pt_ready, 1);

    // Slot 2 takes 5, 3, 7 back to back.
    feed(2, pt_all(5), 1);
    feed(2, pt_all(3), 1);
    feed(2, pt_all(7), 1);
    expect_zero();
    exp_acc[2] = acc_all(15);
    exp_cnt[2] = 10'd3;
    run_drain(1'b0, 1'b0, 1'b0);

    // Lane 1 of slot 0 brought to 2^22-1 (512*8191 + 511), then +1 wraps to 0.
    do_clear();
    feed(0, pt2(8191, 0), 512);
    feed(0, pt2(511, 100), 1);
    feed(0, pt2(1, 0), 1);
    expect_zero();
    exp_acc[0][2*AC-1:AC] = AC'(100);
    exp_cnt[0] = 10'd514;
    run_drain(1'b1, 1'b0, 1'b0);

    // Counter saturation on slot 5.
    do_clear();
    feed(5, pt_all(1), 1023);
    check("sat_before", cnt_sat, 0);
    feed(5, pt_all(1), 1);
    check("sat_after", cnt_sat, 1);
    expect_zero();
    exp_acc[5] = acc_all(1024);
    exp_cnt[5] = 10'd1023;
    run_drain(1'b0, 1'b0, 1'b0);
    check("sat_kept", cnt_sat, 1);
    do_clear();
    expect_zero();
    run_drain(1'b0, 1'b0, 1'b0);

    // clear, drain and a point in the same IDLE cycle: CLEAR wins.
    feed(1, pt_all(2), 1);
    clear    = 1'b1;
    drain    = 1'b1;
    pt_valid = 1'b1;
    pt_idx   = 3'd3;
    pt_data  = pt_all(9);
    @(negedge clk);
    clear    = 1'b0;
    drain    = 1'b0;
    pt_valid = 1'b0;
    check("prio_busy", busy, 1);
    check("prio_valid", out_valid, 0);
    @(negedge clk);
    check("prio_idle_valid", out_valid, 0);
    check("prio_idle_busy", busy, 0);
    expect_zero();
    run_drain(1'b0, 1'b0, 1'b1);
    run_drain(1'b0, 1'b1, 1'b0);
    run_drain(1'b0, 1'b0, 1'b0);

    // Reset while word 3 is on the output.
    feed(7, pt_all(4), 1);
    drain = 1'b1;
    @(negedge clk);
    drain     = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (out_idx != 3'd3 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_word", out_idx, 3);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_idx", out_idx, 0);
    out_ready = 1'b0;
    @(negedge clk);
    check("abort_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", pt_ready, 1);
    check("abort_idle_valid", out_valid, 0);
    expect_zero();
    run_drain(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_controller.md
ACCUMULATOR_CONTROLLER -- requirements
Module: accumulator_controller

Interface
REQ-001 The block SHALL have parameter dataWidth, default 91, meaning packed point width (7 coordinates).
REQ-002 The block SHALL have parameter cordinate_width, default 13, meaning unsigned point coordinate width.
REQ-003 The block SHALL have parameter accum_cord_width, default 22, meaning per-coordinate accumulator width.
REQ-004 The block SHALL have parameter accum_width, default 7*22, meaning packed accumulator width.
REQ-005 The block SHALL have parameter centroid_num, default 8, meaning number of accumulator/counter slots.
REQ-006 The block SHALL have parameter count_width, default 10, meaning per-slot point counter width.
REQ-007 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  start a clear of all slots.
- pt_valid  in  1  point offered.
- pt_ready  out  1  point accepted when pt_valid&&pt_ready.
- pt_data  in  dataWidth  packed point, coordinate 1 in LSBs.
- pt_idx  in  3  target slot, clog2(centroid_num).
- drain  in  1  start readout of all slots.
- out_valid  out  1  readout word valid.
- out_ready  in  1  downstream accepts readout word.
- out_idx  out  3  slot index of readout word.
- out_accum  out  accum_width  slot accumulator.
- out_count  out  count_width  slot point count.
- cnt_sat  out  1  sticky flag: some counter saturated.
- busy  out  1  high in CLEAR or DRAIN.

Function
REQ-008 The block SHALL hold centroid_num accumulator registers (accum_width) and centroid_num counters (count_width).
REQ-009 The block SHALL use a 3-state FSM: IDLE, CLEAR, DRAIN.
REQ-010 In IDLE, pt_ready SHALL be 1; in CLEAR and DRAIN, pt_ready SHALL be 0.
REQ-011 On an accepted point, at the same edge, slot pt_idx accumulator SHALL become, per coordinate, zero-extended coordinate plus stored coordinate, modulo 2^accum_cord_width (no carry between coordinates).
REQ-012 On an accepted point, slot pt_idx counter SHALL increment by 1, saturating at 2^count_width-1; an increment attempted at saturation SHALL set cnt_sat.
REQ-013 Back-to-back points to the same slot SHALL be accepted every cycle, each seeing the previous result (throughput 1 point/cycle, latency 1 cycle).
REQ-014 pt_idx >= centroid_num SHALL accept the point and modify no slot.
REQ-015 IDLE with clear=1 SHALL go to CLEAR; clear takes priority over drain and over pt_valid the same cycle (point not accepted).
REQ-016 CLEAR SHALL last exactly 1 cycle, zero all accumulators, counters and cnt_sat, then return to IDLE.
REQ-017 IDLE with drain=1 and clear=0 SHALL go to DRAIN with readout pointer 0; point not accepted that cycle.
REQ-018 In DRAIN, out_valid SHALL be 1, out_idx the pointer, out_accum/out_count that slot's contents; pointer advances only on out_valid&&out_ready.
REQ-019 out_idx/out_accum/out_count SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Accepting slot centroid_num-1 SHALL return to IDLE next cycle with out_valid=0; slots are not modified by draining.
REQ-021 clear or drain asserted outside IDLE SHALL be ignored.
REQ-022 busy SHALL be 1 exactly when state is CLEAR or DRAIN.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, all accumulators and counters 0, cnt_sat=0, out_valid=0, out_idx=0, busy=0, pt_ready=1 after release.
REQ-024 Reset mid-DRAIN or mid-CLEAR SHALL abandon the operation with no further out_valid.

Verification
REQ-025 Reset, then points to slot 2 with all coordinates 5, 3, 7 on consecutive cycles -> drain gives slot 2 coordinates 15, count 3; other slots 0/0.
REQ-026 Slot 0 coordinate 1 preloaded to 2^22-1, add coordinate 1 = 1 -> coordinate 1 = 0, coordinate 2 unchanged.
REQ-027 1024 points to slot 5 -> count 1023, cnt_sat=1; clear -> count 0, cnt_sat=0.
REQ-028 drain with out_ready toggling 1,0,0,1 -> 8 words, indices 0..7 in order, each held stable during stall, busy low after last.
REQ-029 clear, drain and pt_valid asserted same IDLE cycle -> CLEAR taken, point not accepted, no out_valid.
REQ-030 rst_n low at drain word 3 -> out_valid 0 immediately, all slots 0, pt_ready 1 after release.
